pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and halt controller for the pipelined CPU. It keeps a scoreboard of in-flight register writes for every stage after decode (EX, MEM, WB, …) and drives the stall, flush, bubble and forwarding-select signals that the hand-wired top level currently lacks. It also sequences a clean halt, letting older instructions retire first, and counts stall cycles. It sits beside the pipeline registers and consumes decode-stage fields plus back-end status.

---
 rtl/pipe_hazard_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard hazard, forwarding and halt controller.
// In: ID fields, br_taken, mem_busy. Out: stall/flush/bubble, fwd sels, hlt, stall_cnt.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_READY_SLOT = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src_s,
  input  logic [REG_W-1:0] id_src_t,
  input  logic             id_use_s,
  input  logic             id_use_t,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             id_hlt,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             stall_front,
  output logic             stall_back,
  output logic             flush,
  output logic             bubble,
  output logic [SEL_W-1:0] fwd_s_sel,
  output logic [SEL_W-1:0] fwd_t_sel,
  output logic             hlt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [REG_W-1:0] dst;
    logic             is_load;
  } slot_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  slot_t            sb_q [DEPTH];
  slot_t            slot0_nxt;
  state_t           state_q;
  logic             hlt_q;
  logic [CNT_W-1:0] cnt_q;

  logic [SEL_W-1:0] sel_s;
  logic [SEL_W-1:0] sel_t;
  logic             ld_s;
  logic             ld_t;
  logic             luse;
  logic             accept;
  logic             any_valid;
  logic             sf;
  logic             sbk;
  logic             fl;
  logic             bb;

  function automatic logic match(
    input slot_t            e,
    input logic [REG_W-1:0] r
  );
    logic zr;
    zr = ZERO_REG && (r == '0);
    return e.valid && e.we && (e.dst == r) && !zr;
  endfunction

  // Scan oldest to youngest so the youngest writer lands last.
  always_comb begin
    sel_s = '0;
    sel_t = '0;
    ld_s  = 1'b0;
    ld_t  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (id_use_s && match(sb_q[k], id_src_s)) begin
        sel_s = SEL_W'(k + 1);
        ld_s  = sb_q[k].is_load && (k < LOAD_READY_SLOT);
      end
      if (id_use_t && match(sb_q[k], id_src_t)) begin
        sel_t = SEL_W'(k + 1);
        ld_t  = sb_q[k].is_load && (k < LOAD_READY_SLOT);
      end
    end
  end

  assign luse = id_valid && (ld_s || ld_t);

  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any_valid = any_valid | sb_q[k].valid;
    end
  end

  always_comb begin
    sf     = 1'b0;
    sbk    = 1'b0;
    fl     = 1'b0;
    bb     = 1'b0;
    accept = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          sf  = 1'b1;
          sbk = 1'b1;
        end else if (br_taken) begin
          fl = 1'b1;
          bb = 1'b1;
        end else if (luse) begin
          sf = 1'b1;
          bb = 1'b1;
        end else begin
          accept = id_valid;
        end
      end
      S_DRAIN: begin
        if (mem_busy) begin
          sf  = 1'b1;
          sbk = 1'b1;
        end else begin
          sf = 1'b1;
          bb = 1'b1;
        end
      end
      S_HALTED: begin
        sf  = 1'b1;
        sbk = 1'b1;
      end
      default: begin
        sf  = 1'b1;
        sbk = 1'b1;
      end
    endcase
  end

  // Busy-input paths must not leak out while reset is held.
  assign stall_front = sf && rst_n;
  assign stall_back  = sbk && rst_n;
  assign flush       = fl && rst_n;
  assign bubble      = bb && rst_n;
  assign fwd_s_sel   = sel_s;
  assign fwd_t_sel   = sel_t;
  assign hlt         = hlt_q;
  assign stall_cnt   = cnt_q;

  // A halt travels down the pipe as a non-writing marker.
  always_comb begin
    slot0_nxt = '0;
    if (accept) begin
      slot0_nxt.valid   = 1'b1;
      slot0_nxt.we      = id_we && !id_hlt;
      slot0_nxt.dst     = id_dst;
      slot0_nxt.is_load = id_is_load && !id_hlt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
    end else if (!mem_busy) begin
      sb_q[0] <= slot0_nxt;
      for (int k = 1; k < DEPTH; k++) begin
        sb_q[k] <= sb_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      hlt_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (accept && id_hlt) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!mem_busy && !any_valid) begin
            state_q <= S_HALTED;
            hlt_q   <= 1'b1;
          end
        end
        S_HALTED: begin
          hlt_q <= 1'b1;
        end
        default: begin
          state_q <= S_RUN;
          hlt_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_front && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl.
// Second instance uses ZERO_REG=0 for the r0 case.
module tb_pipe_hazard_ctrl;

  localparam int DEPTH = 3;
  localparam int SEL_W = 2;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_src_s;
  logic [4:0] id_src_t;
  logic       id_use_s;
  logic       id_use_t;
  logic [4:0] id_dst;
  logic       id_we;
  logic       id_is_load;
  logic       id_hlt;
  logic       br_taken;
  logic       mem_busy;

  logic             sf, sb, fl, bb, hl;
  logic [SEL_W-1:0] fs, ft;
  logic [15:0]      cnt;
  logic             sf0, sb0, fl0, bb0, hl0;
  logic [SEL_W-1:0] fs0, ft0;
  logic [15:0]      cnt0;

  int n_chk;
  int n_fail;
  logic [15:0] cnt_ref;

  pipe_hazard_ctrl #(.REG_W(5), .DEPTH(DEPTH), .LOAD_READY_SLOT(1),
                     .ZERO_REG(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_s(id_src_s), .id_src_t(id_src_t),
    .id_use_s(id_use_s), .id_use_t(id_use_t),
    .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load),
    .id_hlt(id_hlt), .br_taken(br_taken), .mem_busy(mem_busy),
    .stall_front(sf), .stall_back(sb), .flush(fl), .bubble(bb),
    .fwd_s_sel(fs), .fwd_t_sel(ft), .hlt(hl), .stall_cnt(cnt)
  );

  pipe_hazard_ctrl #(.REG_W(5), .DEPTH(DEPTH), .LOAD_READY_SLOT(1),
                     .ZERO_REG(1'b0), .CNT_W(16)) u_dut_z0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_s(id_src_s), .id_src_t(id_src_t),
    .id_use_s(id_use_s), .id_use_t(id_use_t),
    .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load),
    .id_hlt(id_hlt), .br_taken(br_taken), .mem_busy(mem_busy),
    .stall_front(sf0), .stall_back(sb0), .flush(fl0), .bubble(bb0),
    .fwd_s_sel(fs0), .fwd_t_sel(ft0), .hlt(hl0), .stall_cnt(cnt0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] s, input logic us,
                     input logic [4:0] t, input logic ut, input logic [4:0] d,
                     input logic we, input logic ld, input logic h);
    id_valid   = v;
    id_src_s   = s;
    id_use_s   = us;
    id_src_t   = t;
    id_use_t   = ut;
    id_dst     = d;
    id_we      = we;
    id_is_load = ld;
    id_hlt     = h;
    #2;
  endtask

  task automatic idle();
    br_taken = 1'b0;
    mem_busy = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    br_taken = 1'b1;
    mem_busy = 1'b1;
    drv(1, 3, 1, 4, 1, 5, 1, 0, 1);
    #3;
    n_chk++;
    if ({sf, sb, fl, bb, hl} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b need 00000", {sf, sb, fl, bb, hl});
    end
    n_chk++;
    if ({fs, ft} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_fwd got %b need 0000", {fs, ft});
    end
    n_chk++;
    if (cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d need 0", cnt);
    end
    br_taken = 1'b0;
    mem_busy = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    drv(1, 1, 1, 2, 1, 4, 1, 1, 0);
    n_chk++;
    if (sf !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_load_stall got %b need 0", sf);
    end
    tick();
    drv(1, 4, 1, 0, 0, 6, 1, 0, 0);
    n_chk++;
    if ({sf, sb, fl, bb} !== 4'b1001) begin
      n_fail++;
      $display("FAIL lu_stall got %b need 1001", {sf, sb, fl, bb});
    end
    tick();
    n_chk++;
    if ({sf, bb, fs} !== 4'b0010) begin
      n_fail++;
      $display("FAIL lu_fwd got %b need 0010", {sf, bb, fs});
    end
    n_chk++;
    if (cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_cnt got %0d need 1", cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_fwd_chain();
    logic [SEL_W-1:0] exp_s [5];
    exp_s[0] = 2'd0;
    exp_s[1] = 2'd1;
    exp_s[2] = 2'd2;
    exp_s[3] = 2'd3;
    exp_s[4] = 2'd0;
    drv(1, 1, 1, 2, 1, 3, 1, 0, 0);
    tick();
    for (int i = 1; i < 5; i++) begin
      drv(1, 3, 1, 3, 0, 5'(8 + i), 1, 0, 0);
      n_chk++;
      if ({sf, fs, ft} !== {1'b0, exp_s[i], 2'd0}) begin
        n_fail++;
        $display("FAIL fwd_chain_%0d got sf=%b s=%0d t=%0d need 0/%0d/0",
                 i, sf, fs, ft, exp_s[i]);
      end
      tick();
    end
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    drv(1, 0, 0, 7, 1, 1, 1, 0, 0);
    n_chk++;
    if (ft !== 2'd1) begin
      n_fail++;
      $display("FAIL fwd_youngest got %0d need 1", ft);
    end
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    drv(1, 1, 0, 1, 0, 0, 1, 0, 0);
    tick();
    drv(1, 0, 1, 0, 0, 2, 1, 0, 0);
    n_chk++;
    if ({sf, fs} !== 3'b000) begin
      n_fail++;
      $display("FAIL zero_reg got sf=%b sel=%0d need 0/0", sf, fs);
    end
    n_chk++;
    if (fs0 !== 2'd1) begin
      n_fail++;
      $display("FAIL zero_reg_off got %0d need 1", fs0);
    end
    tick();
    idle();
  endtask

  task automatic test_branch_luse();
    cnt_ref = cnt;
    drv(1, 0, 0, 0, 0, 4, 1, 1, 0);
    tick();
    br_taken = 1'b1;
    drv(1, 4, 1, 0, 0, 4, 1, 0, 1);
    n_chk++;
    if ({sf, sb, fl, bb} !== 4'b0011) begin
      n_fail++;
      $display("FAIL br_luse got %b need 0011", {sf, sb, fl, bb});
    end
    tick();
    br_taken = 1'b0;
    drv(1, 4, 1, 0, 0, 2, 1, 0, 0);
    n_chk++;
    if ({sf, fs} !== 3'b010) begin
      n_fail++;
      $display("FAIL br_squash got sf=%b sel=%0d need 0/2", sf, fs);
    end
    n_chk++;
    if (hl !== 1'b0 || cnt !== cnt_ref) begin
      n_fail++;
      $display("FAIL br_nohalt got hlt=%b cnt=%0d need 0/%0d", hl, cnt, cnt_ref);
    end
    tick();
    idle();
  endtask

  task automatic test_busy_freeze();
    cnt_ref = cnt;
    drv(1, 0, 0, 0, 0, 8, 1, 0, 0);
    tick();
    drv(1, 8, 1, 0, 0, 9, 1, 0, 0);
    tick();
    drv(1, 8, 1, 9, 1, 10, 1, 0, 0);
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_taken = (i == 2);
      #1;
      n_chk++;
      if ({sf, sb, fl, bb, fs, ft} !== 8'b1100_10_01) begin
        n_fail++;
        $display("FAIL busy_%0d got %b need 11001001", i, {sf, sb, fl, bb, fs, ft});
      end
      tick();
    end
    mem_busy = 1'b0;
    br_taken = 1'b0;
    #1;
    n_chk++;
    if ({sf, sb, bb, fs, ft} !== 7'b000_10_01) begin
      n_fail++;
      $display("FAIL busy_after got %b need 0001001", {sf, sb, bb, fs, ft});
    end
    n_chk++;
    if (cnt !== cnt_ref + 16'd5) begin
      n_fail++;
      $display("FAIL busy_cnt got %0d need %0d", cnt, cnt_ref + 16'd5);
    end
    tick();
    idle();
  endtask

  task automatic test_halt();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1);
    n_chk++;
    if (sf !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_accept got sf=%b need 0", sf);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= DEPTH + 2; c++) begin
      mem_busy = (c <= 2);
      br_taken = (c == 3);
      #1;
      n_chk++;
      if ({hl, sf, sb, fl, bb} !== {1'b0, 1'b1, mem_busy, 1'b0, !mem_busy}) begin
        n_fail++;
        $display("FAIL drain_%0d got %b need %b", c, {hl, sf, sb, fl, bb},
                 {1'b0, 1'b1, mem_busy, 1'b0, !mem_busy});
      end
      tick();
    end
    mem_busy = 1'b0;
    br_taken = 1'b0;
    #1;
    n_chk++;
    if (hl !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_early got %b need 0", hl);
    end
    tick();
    n_chk++;
    if ({hl, sf, sb} !== 3'b111) begin
      n_fail++;
      $display("FAIL halt_rise got %b need 111", {hl, sf, sb});
    end
    repeat (3) tick();
    n_chk++;
    if (hl !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_sticky got %b need 1", hl);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({hl, sf, sb} !== 3'b000) begin
      n_fail++;
      $display("FAIL halt_rst got %b need 000", {hl, sf, sb});
    end
    rst_n = 1'b1;
    tick();
    drv(1, 1, 1, 0, 0, 2, 1, 0, 0);
    n_chk++;
    if ({hl, sf, cnt} !== {2'b00, 16'd0}) begin
      n_fail++;
      $display("FAIL halt_run got hlt=%b sf=%b cnt=%0d need 0/0/0", hl, sf, cnt);
    end
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_load_use();
    test_fwd_chain();
    test_zero_reg();
    test_branch_luse();
    test_busy_freeze();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running need finished");
    $fatal(1, "timeout");
  end

endmodule
